vga_rect_fill_master: RTL

- Bus initiator that fills a rectangle of the 160x120 1-bit frame buffer.
- Issues write transactions on the shared 8-bit memory-mapped bus to the VGA peripheral register bank at BASE_ADDR..BASE_ADDR+3:
  - +0: Y
  - +1: X
  - +2: colour bit
  - +3: write-enable bit
- Offloads pixel-by-pixel fills from the processor.
- Arbitrates for the bus through a REQ/GNT pair and releases the bus between pixels.

---
 rtl/vga_rect_fill_master.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vga_rect_fill_master.sv
// Rectangle fill bus master: walks the rectangle row-major and skips pixels outside the frame.
// For each visible pixel it writes Y, X, colour and a WE pulse to the VGA register bank.
module vga_rect_fill_master #(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int         H_PIXELS  = 160,
  parameter int         V_PIXELS  = 120
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] X0,
  input  logic [6:0] Y0,
  input  logic [7:0] WIDTH,
  input  logic [6:0] HEIGHT,
  input  logic       COLOUR,
  input  logic       BUS_GNT,
  output logic       BUS_REQ,
  output logic       BUS_OE,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] BUS_DATA,
  output logic       BUS_WE,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_REQ, S_WR_Y, S_WR_X, S_WR_C, S_WE_HI, S_WE_LO, S_NEXT, S_DONE
  } state_t;

  localparam logic [8:0] H_LIM = 9'(H_PIXELS);
  localparam logic [7:0] V_LIM = 8'(V_PIXELS);

  state_t     state_r, state_nxt_s;
  logic       stall_r, stall_nxt_s;
  logic [7:0] x0_r, w_r, x_cnt_r, x_cnt_nxt_s;
  logic [6:0] y0_r, h_r, y_cnt_r, y_cnt_nxt_s;
  logic       colour_r;
  logic [8:0] px_s;
  logic [7:0] py_s;
  logic       clip_s, empty_s, last_x_s, last_s;

  logic       req_nxt_s, oe_nxt_s, we_nxt_s, busy_nxt_s, done_nxt_s;
  logic [7:0] addr_nxt_s, data_nxt_s;
  logic       bus_req_r, bus_oe_r, bus_we_r, busy_r, done_r;
  logic [7:0] bus_addr_r, bus_data_r;

  // Widened sums so X0=255 plus a column offset lands past the frame instead of wrapping.
  assign px_s     = {1'b0, x0_r} + {1'b0, x_cnt_r};
  assign py_s     = {1'b0, y0_r} + {1'b0, y_cnt_r};
  assign clip_s   = (px_s >= H_LIM) || (py_s >= V_LIM);
  assign empty_s  = (w_r == 8'd0) || (h_r == 7'd0);
  assign last_x_s = (x_cnt_r == (w_r - 8'd1));
  assign last_s   = last_x_s && (y_cnt_r == (h_r - 7'd1));

  // Next-state, counter advance and write-stall tracking.
  always_comb begin
    state_nxt_s = state_r;
    stall_nxt_s = 1'b0;
    x_cnt_nxt_s = x_cnt_r;
    y_cnt_nxt_s = y_cnt_r;
    case (state_r)
      S_IDLE: begin
        if (START) begin
          state_nxt_s = S_CHK;
          x_cnt_nxt_s = 8'd0;
          y_cnt_nxt_s = 7'd0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CHK: begin
        if (empty_s)     state_nxt_s = S_DONE;
        else if (clip_s) state_nxt_s = S_NEXT;
        else             state_nxt_s = S_REQ;
      end
      S_REQ: begin
        if (BUS_GNT) state_nxt_s = S_WR_Y;
        else         state_nxt_s = S_REQ;
      end
      S_WR_Y, S_WR_X, S_WR_C, S_WE_HI, S_WE_LO: begin
        // A write only completes once it has been driven with the grant held.
        if (!BUS_GNT) begin
          stall_nxt_s = 1'b1;
        end else if (stall_r) begin
          stall_nxt_s = 1'b0;
        end else begin
          case (state_r)
            S_WR_Y:  state_nxt_s = S_WR_X;
            S_WR_X:  state_nxt_s = S_WR_C;
            S_WR_C:  state_nxt_s = S_WE_HI;
            S_WE_HI: state_nxt_s = S_WE_LO;
            default: state_nxt_s = S_NEXT;
          endcase
        end
      end
      S_NEXT: begin
        if (last_x_s) begin
          x_cnt_nxt_s = 8'd0;
          y_cnt_nxt_s = y_cnt_r + 7'd1;
        end else begin
          x_cnt_nxt_s = x_cnt_r + 8'd1;
        end
        if (last_s) state_nxt_s = S_DONE;
        else        state_nxt_s = S_CHK;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    req_nxt_s  = 1'b0;
    oe_nxt_s   = 1'b0;
    we_nxt_s   = 1'b0;
    addr_nxt_s = 8'h00;
    data_nxt_s = 8'h00;
    busy_nxt_s = (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
    done_nxt_s = (state_nxt_s == S_DONE);
    case (state_nxt_s)
      S_REQ: req_nxt_s = 1'b1;
      S_WR_Y, S_WR_X, S_WR_C, S_WE_HI, S_WE_LO: begin
        req_nxt_s = 1'b1;
        if (!stall_nxt_s) begin
          oe_nxt_s = 1'b1;
          we_nxt_s = 1'b1;
          case (state_nxt_s)
            S_WR_Y: begin addr_nxt_s = BASE_ADDR;         data_nxt_s = {1'b0, py_s[6:0]}; end
            S_WR_X: begin addr_nxt_s = BASE_ADDR + 8'd1;  data_nxt_s = px_s[7:0];         end
            S_WR_C: begin addr_nxt_s = BASE_ADDR + 8'd2;  data_nxt_s = {7'd0, colour_r};  end
            S_WE_HI: begin addr_nxt_s = BASE_ADDR + 8'd3; data_nxt_s = 8'h01;             end
            default: begin addr_nxt_s = BASE_ADDR + 8'd3; data_nxt_s = 8'h00;             end
          endcase
        end else begin
          oe_nxt_s = 1'b0;
        end
      end
      default: req_nxt_s = 1'b0;
    endcase
  end

  // State, walk counters and command latch.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r  <= S_IDLE;
      stall_r  <= 1'b0;
      x_cnt_r  <= 8'd0;
      y_cnt_r  <= 7'd0;
      x0_r     <= 8'd0;
      y0_r     <= 7'd0;
      w_r      <= 8'd0;
      h_r      <= 7'd0;
      colour_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      stall_r <= stall_nxt_s;
      x_cnt_r <= x_cnt_nxt_s;
      y_cnt_r <= y_cnt_nxt_s;
      if ((state_r == S_IDLE) && START) begin
        x0_r     <= X0;
        y0_r     <= Y0;
        w_r      <= WIDTH;
        h_r      <= HEIGHT;
        colour_r <= COLOUR;
      end
    end
  end

  // Registered bus and status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus_req_r  <= 1'b0;
      bus_oe_r   <= 1'b0;
      bus_we_r   <= 1'b0;
      bus_addr_r <= 8'h00;
      bus_data_r <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      bus_req_r  <= req_nxt_s;
      bus_oe_r   <= oe_nxt_s;
      bus_we_r   <= we_nxt_s;
      bus_addr_r <= addr_nxt_s;
      bus_data_r <= data_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign BUS_REQ  = bus_req_r;
  assign BUS_OE   = bus_oe_r;
  assign BUS_WE   = bus_we_r;
  assign BUS_ADDR = bus_addr_r;
  assign BUS_DATA = bus_data_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;

endmodule
